// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdb_pkg
// Brief    : Completion-bus widths, slot layout and helpers shared by the
//            arbiter, the ROB complete ports and the wakeup logic.
// Revision : 1.0
// ============================================================================
package cdb_pkg;

   localparam int CDB_PC_W   = 32;
   localparam int CDB_DATA_W = 32;
   localparam int CDB_PREG_W = 6;

   // The ROB treats a completion PC of zero as an empty slot.
   localparam int unsigned PC_NONE = 0;

   typedef struct packed {
      logic                  valid;
      logic [CDB_PC_W-1:0]   pc;
      logic [CDB_PREG_W-1:0] preg;
      logic [CDB_DATA_W-1:0] data;
   } cdb_slot_t;

   localparam int SLOT_DATA_LSB  = 0;
   localparam int SLOT_PREG_LSB  = SLOT_DATA_LSB + CDB_DATA_W;
   localparam int SLOT_PC_LSB    = SLOT_PREG_LSB + CDB_PREG_W;
   localparam int SLOT_VALID_BIT = SLOT_PC_LSB + CDB_PC_W;
   localparam int SLOT_W         = SLOT_VALID_BIT + 1;

   function automatic int unsigned count_ones(input logic [7:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

endpackage : cdb_pkg
`default_nettype wire

// File: rtl/cdb_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Finds the first valid, not-yet-picked requester scanning from
//            a start pointer with modulo-N wrap.
// Revision : 1.0
// ============================================================================
module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     valid,
   input  logic [PTR_W-1:0] start,
   input  logic [N-1:0]     mask,
   output logic [PTR_W-1:0] idx,
   output logic             found
);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] pos;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         // N need not be a power of two, so wrap by compare rather than truncation.
         sum = {1'b0, start} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(N)) begin
            sum = sum - (PTR_W+1)'(N);
         end
         pos = sum[PTR_W-1:0];
         if (!found && valid[pos] && !mask[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin arbiter placing up to NUM_BUS functional-unit
//            completions per cycle onto registered completion-bus slots.
// Revision : 1.0
// ============================================================================
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int NUM_BUS = 2,
   parameter int PC_W    = CDB_PC_W,
   parameter int DATA_W  = CDB_DATA_W,
   parameter int PREG_W  = CDB_PREG_W,
   parameter int CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        flush,
   input  logic                        cdb_hold,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*PC_W-1:0]     req_pc,
   input  logic [NUM_REQ*PREG_W-1:0]   req_preg,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_BUS-1:0]          cdb_valid,
   output logic [NUM_BUS*PC_W-1:0]     cdb_pc,
   output logic [NUM_BUS*PREG_W-1:0]   cdb_preg,
   output logic [NUM_BUS*DATA_W-1:0]   cdb_data,
   output logic [CNT_W-1:0]            contention_cnt
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]   rr_ptr;
   logic [NUM_REQ-1:0] mask [NUM_BUS+1];
   logic [PTR_W-1:0]   pick_idx [NUM_BUS];
   logic [NUM_BUS-1:0] pick_found;
   logic               grant_en;
   logic               over_sub;
   logic [PTR_W-1:0]   last_idx;
   logic [PTR_W:0]     ptr_inc;
   logic [PTR_W-1:0]   ptr_nxt;

   logic [NUM_BUS-1:0]        nxt_valid;
   logic [NUM_BUS*PC_W-1:0]   nxt_pc;
   logic [NUM_BUS*PREG_W-1:0] nxt_preg;
   logic [NUM_BUS*DATA_W-1:0] nxt_data;

   assign grant_en = rstn & ~flush & ~cdb_hold;
   assign over_sub = count_ones(8'(req_valid)) > NUM_BUS;

   // Each picker masks out everything the earlier slots already took.
   assign mask[0] = '0;

   generate
      for (genvar b = 0; b < NUM_BUS; b++) begin : g_slot
         rr_pick #(
            .N     (NUM_REQ),
            .PTR_W (PTR_W)
         ) u_pick (
            .valid (req_valid),
            .start (rr_ptr),
            .mask  (mask[b]),
            .idx   (pick_idx[b]),
            .found (pick_found[b])
         );
         assign mask[b+1] = mask[b] |
                            (pick_found[b] ? (NUM_REQ'(1) << pick_idx[b]) : '0);
      end
   endgenerate

   assign req_ready = grant_en ? mask[NUM_BUS] : '0;

   always_comb begin
      last_idx = '0;
      for (int b = 0; b < NUM_BUS; b++) begin
         if (pick_found[b]) begin
            last_idx = pick_idx[b];
         end
      end
      ptr_inc = {1'b0, last_idx} + (PTR_W+1)'(1);
      if (ptr_inc >= (PTR_W+1)'(NUM_REQ)) begin
         ptr_nxt = '0;
      end else begin
         ptr_nxt = ptr_inc[PTR_W-1:0];
      end
   end

   always_comb begin
      nxt_valid = '0;
      nxt_pc    = {NUM_BUS{PC_W'(PC_NONE)}};
      nxt_preg  = '0;
      nxt_data  = '0;
      for (int b = 0; b < NUM_BUS; b++) begin
         for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_en && pick_found[b] && pick_idx[b] == PTR_W'(r)) begin
               nxt_valid[b]                  = 1'b1;
               nxt_pc[b*PC_W +: PC_W]        = req_pc[r*PC_W +: PC_W];
               nxt_preg[b*PREG_W +: PREG_W]  = req_preg[r*PREG_W +: PREG_W];
               nxt_data[b*DATA_W +: DATA_W]  = req_data[r*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_ptr         <= '0;
         cdb_valid      <= '0;
         cdb_pc         <= '0;
         cdb_preg       <= '0;
         cdb_data       <= '0;
         contention_cnt <= '0;
      end else begin
         cdb_valid <= nxt_valid;
         cdb_pc    <= nxt_pc;
         cdb_preg  <= nxt_preg;
         cdb_data  <= nxt_data;
         if (flush) begin
            rr_ptr <= '0;
         end else if (grant_en && pick_found[0]) begin
            rr_ptr <= ptr_nxt;
         end
         if (!flush && over_sub && contention_cnt != '1) begin
            contention_cnt <= contention_cnt + CNT_W'(1);
         end
      end
   end

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed self-checking bench for cdb_arbiter (4 FUs, 2 slots).
// Revision : 1.0
// ============================================================================
module tb_cdb_arbiter;

   logic         clk = 1'b0;
   logic         rstn;
   logic         flush;
   logic         cdb_hold;
   logic [3:0]   req_valid;
   logic [127:0] req_pc;
   logic [23:0]  req_preg;
   logic [127:0] req_data;
   logic [3:0]   req_ready;
   logic [1:0]   cdb_valid;
   logic [63:0]  cdb_pc;
   logic [11:0]  cdb_preg;
   logic [63:0]  cdb_data;
   logic [15:0]  contention_cnt;

   logic [3:0]   s_ready;
   logic [1:0]   s_valid;
   logic [63:0]  s_pc;
   logic [11:0]  s_preg;
   logic [63:0]  s_data;
   logic [1:0]   s_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_REQ(4), .NUM_BUS(2), .CNT_W(16)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .cdb_hold(cdb_hold),
      .req_valid(req_valid), .req_pc(req_pc), .req_preg(req_preg),
      .req_data(req_data), .req_ready(req_ready), .cdb_valid(cdb_valid),
      .cdb_pc(cdb_pc), .cdb_preg(cdb_preg), .cdb_data(cdb_data),
      .contention_cnt(contention_cnt)
   );

   // Narrow counter instance to reach saturation in a few cycles.
   cdb_arbiter #(.NUM_REQ(4), .NUM_BUS(2), .CNT_W(2)) dut_sat (
      .clk(clk), .rstn(rstn), .flush(flush), .cdb_hold(cdb_hold),
      .req_valid(req_valid), .req_pc(req_pc), .req_preg(req_preg),
      .req_data(req_data), .req_ready(s_ready), .cdb_valid(s_valid),
      .cdb_pc(s_pc), .cdb_preg(s_preg), .cdb_data(s_data),
      .contention_cnt(s_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive at negedge, check the combinational grant, then advance past the edge.
   task automatic step(input logic [3:0] v, input logic h, input logic f,
                       input logic [3:0] exp_ready, input string tag);
      @(negedge clk);
      req_valid = v;
      cdb_hold  = h;
      flush     = f;
      #1;
      chk({tag, "_ready"}, 64'(req_ready), 64'(exp_ready));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_slots(input string tag, input logic [1:0] v,
                            input logic [31:0] pc0, input logic [31:0] pc1);
      chk({tag, "_valid"}, 64'(cdb_valid), 64'(v));
      chk({tag, "_pc0"}, 64'(cdb_pc[31:0]), 64'(pc0));
      chk({tag, "_pc1"}, 64'(cdb_pc[63:32]), 64'(pc1));
   endtask

   initial begin
      // FU payloads: pc 0x20/0x30/0x40/0x50, preg 3..6, data per table.
      req_pc   = {32'h50, 32'h40, 32'h30, 32'h20};
      req_preg = {6'd6, 6'd5, 6'd4, 6'd3};
      req_data = {32'hDD00, 32'h11, 32'hBB00, 32'hAA00};
      rstn = 1'b0; flush = 1'b0; cdb_hold = 1'b0; req_valid = 4'b1111;
      #12;
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_valid", 64'(cdb_valid), 64'h0);
      chk("rst_cnt", 64'(contention_cnt), 64'h0);
      req_valid = 4'b0000;
      @(negedge clk);
      rstn = 1'b1;

      step(4'b0000, 1'b0, 1'b0, 4'b0000, "idle");
      chk_slots("idle", 2'b00, 32'h0, 32'h0);
      chk("idle_ptr", 64'(dut.rr_ptr), 64'd0);

      step(4'b0100, 1'b0, 1'b0, 4'b0100, "single");
      chk_slots("single", 2'b01, 32'h40, 32'h0);
      chk("single_preg0", 64'(cdb_preg[5:0]), 64'd5);
      chk("single_data0", 64'(cdb_data[31:0]), 64'h11);
      chk("single_data1", 64'(cdb_data[63:32]), 64'h0);
      chk("single_ptr", 64'(dut.rr_ptr), 64'd3);

      step(4'b1001, 1'b0, 1'b0, 4'b1001, "wrap");
      chk_slots("wrap", 2'b11, 32'h50, 32'h20);
      chk("wrap_preg1", 64'(cdb_preg[11:6]), 64'd3);
      chk("wrap_data0", 64'(cdb_data[31:0]), 64'hDD00);
      chk("wrap_ptr", 64'(dut.rr_ptr), 64'd1);

      step(4'b1111, 1'b1, 1'b1, 4'b0000, "flush");
      chk_slots("flush", 2'b00, 32'h0, 32'h0);
      chk("flush_ptr", 64'(dut.rr_ptr), 64'd0);
      chk("flush_cnt", 64'(contention_cnt), 64'd0);

      step(4'b1111, 1'b0, 1'b0, 4'b0011, "cont1");
      chk_slots("cont1", 2'b11, 32'h20, 32'h30);
      chk("cont1_cnt", 64'(contention_cnt), 64'd1);
      step(4'b1111, 1'b0, 1'b0, 4'b1100, "cont2");
      chk_slots("cont2", 2'b11, 32'h40, 32'h50);
      chk("cont2_cnt", 64'(contention_cnt), 64'd2);
      step(4'b1111, 1'b0, 1'b0, 4'b0011, "cont3");
      chk_slots("cont3", 2'b11, 32'h20, 32'h30);
      chk("cont3_cnt", 64'(contention_cnt), 64'd3);
      chk("cont3_ptr", 64'(dut.rr_ptr), 64'd2);
      chk("sat_cnt3", 64'(s_cnt), 64'd3);

      step(4'b0011, 1'b1, 1'b0, 4'b0000, "hold");
      chk_slots("hold", 2'b00, 32'h0, 32'h0);
      chk("hold_ptr", 64'(dut.rr_ptr), 64'd2);
      chk("hold_cnt", 64'(contention_cnt), 64'd3);

      step(4'b0111, 1'b1, 1'b0, 4'b0000, "holdc");
      chk("holdc_cnt", 64'(contention_cnt), 64'd4);
      chk("holdc_sat", 64'(s_cnt), 64'd3);
      step(4'b1111, 1'b0, 1'b0, 4'b1100, "sat");
      chk("sat_stay", 64'(s_cnt), 64'd3);
      chk("sat_main", 64'(contention_cnt), 64'd5);

      step(4'b0010, 1'b0, 1'b0, 4'b0010, "nogap");
      chk_slots("nogap", 2'b01, 32'h30, 32'h0);
      chk("nogap_preg1", 64'(cdb_preg[11:6]), 64'd0);
      chk("nogap_ptr", 64'(dut.rr_ptr), 64'd2);

      step(4'b0000, 1'b0, 1'b0, 4'b0000, "pulse");
      chk("pulse_valid", 64'(cdb_valid), 64'h0);

      step(4'b0001, 1'b0, 1'b0, 4'b0001, "pre_rst");
      chk_slots("pre_rst", 2'b01, 32'h20, 32'h0);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_valid", 64'(cdb_valid), 64'h0);
      chk("arst_pc0", 64'(cdb_pc[31:0]), 64'h0);
      chk("arst_cnt", 64'(contention_cnt), 64'h0);
      chk("arst_ready", 64'(req_ready), 64'h0);
      @(negedge clk);
      req_valid = 4'b0000;
      rstn = 1'b1;
      step(4'b0000, 1'b0, 1'b0, 4'b0000, "post_rst");
      chk("post_rst_valid", 64'(cdb_valid), 64'h0);
      chk("post_rst_ptr", 64'(dut.rr_ptr), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cdb_arbiter
`default_nettype wire
